// File: rtl/tge_tx_packetizer.sv
// Purpose : cuts a 64-bit sample stream into fixed-length UDP payload frames for the
//           10GbE core TX, each frame led by a header word {16'hA55A, seq[47:0]}.
// Latency : 1 clk from input handshake to tx_* (all tx_* outputs are registered).
// Backpr. : in_ready = !tx_afull during payload, so a single word can still land after afull is seen.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              start new frames while high (checked only between frames)
//   dest_ip, dest_port  destination, captured when a frame starts
//   in_valid/in_ready/in_data   source stream, word taken when in_valid && in_ready
//   tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port   to core
//   tx_afull, tx_overflow       from core
//   pkt_count           frames completed (wrapping)
//   overflow_count      cycles with tx_overflow high (saturating)
module tge_tx_packetizer #(
  parameter int          PAYLOAD_WORDS = 128,
  parameter int          GAP_CYCLES    = 2,
  // Value seq takes on reset; nonzero only to exercise the 48-bit wrap quickly.
  parameter logic [47:0] SEQ_INIT      = 48'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        tx_valid,
  output logic        tx_end_of_frame,
  output logic [63:0] tx_data,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  input  logic        tx_afull,
  input  logic        tx_overflow,
  output logic [31:0] pkt_count,
  output logic [15:0] overflow_count
);

  localparam int             CW       = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(PAYLOAD_WORDS - 1);
  localparam logic [7:0]     GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [15:0]    HDR_TAG  = 16'hA55A;

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] word_cnt;
  logic [7:0]    gap_cnt;
  logic [47:0]   seq;
  logic          start;
  logic          hs;
  logic          last;

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    hs        = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !tx_afull && in_valid) begin
          start     = 1'b1;
          state_nxt = HDR;
        end
      end
      // Header goes out regardless of afull; the core's afull margin absorbs it.
      HDR: state_nxt = PAY;
      PAY: begin
        in_ready = !tx_afull;
        hs       = in_valid && !tx_afull;
        if (hs && (word_cnt == LAST_IDX)) begin
          last      = 1'b1;
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered transmit path and frame bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_data         <= 64'd0;
      tx_dest_ip      <= 32'd0;
      tx_dest_port    <= 16'd0;
      word_cnt        <= '0;
      gap_cnt         <= 8'd0;
      seq             <= SEQ_INIT;
      pkt_count       <= 32'd0;
    end else begin
      // tx_valid / end_of_frame are one-cycle strobes per word.
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;

      if (start) begin
        tx_dest_ip   <= dest_ip;
        tx_dest_port <= dest_port;
        word_cnt     <= '0;
      end

      if (state == HDR) begin
        tx_valid <= 1'b1;
        tx_data  <= {HDR_TAG, seq};
      end

      if (hs) begin
        tx_valid <= 1'b1;
        tx_data  <= in_data;
        word_cnt <= word_cnt + 1'b1;
      end

      if (last) begin
        tx_end_of_frame <= 1'b1;
        seq             <= seq + 48'd1;
        pkt_count       <= pkt_count + 32'd1;
      end

      // Gap counter runs only in GAP and is zero on entry.
      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else              gap_cnt <= 8'd0;
    end
  end

  // Overflow cycles are counted independently of the framing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_count <= 16'd0;
    end else if (tx_overflow && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

endmodule

// File: doc/tge_tx_packetizer.md
# tge_tx_packetizer

Application-side framing stage that sits directly upstream of the 10GbE core's transmit interface. It takes a continuous 64-bit sample stream and cuts it into fixed-length UDP payload frames. Each frame starts with a header word that carries a 48-bit sequence number. Frames are driven onto the core's tx_valid/tx_end_of_frame/tx_data/tx_dest_ip/tx_dest_port inputs, with back-pressure taken from tx_afull.

## Interface
Parameters:
- PAYLOAD_WORDS, 128: data words per frame, excluding the header; legal range 1..1024.
- GAP_CYCLES, 2: idle cycles forced after each end-of-frame; legal range 0..255.

Ports:
- clk  in  1  application clock, the same clock as the core's transmit side
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- enable  in  1  start new frames while high
- dest_ip  in  32  destination IP, sampled at frame start
- dest_port  in  16  destination UDP port, sampled at frame start
- in_valid  in  1  source word valid
- in_data  in  64  source word
- in_ready  out  1  word accepted when in_valid && in_ready
- tx_valid  out  1  to core
- tx_end_of_frame  out  1  to core
- tx_data  out  64  to core
- tx_dest_ip  out  32  to core
- tx_dest_port  out  16  to core
- tx_afull  in  1  from core, almost full
- tx_overflow  in  1  from core, frame dropped
- pkt_count  out  32  frames completed, wrapping
- overflow_count  out  16  cycles with tx_overflow high, saturating

## Operation
- FSM states: IDLE, HDR, PAY, GAP.
- **IDLE**
  - in_ready=0.
  - Condition: enable && !tx_afull && in_valid.
  - When true: latch dest_ip/dest_port into tx_dest_ip/tx_dest_port, clear word counter, go to HDR.
- **HDR**
  - Drives tx_valid=1 and tx_data={16'hA55A, seq[47:0]} for exactly one cycle.
  - in_ready=0.
  - Next state is PAY unconditionally, ignoring tx_afull; the core's afull margin covers this word.
- **PAY**
  - in_ready = !tx_afull, combinational from the state register and tx_afull.
  - On each handshake: tx_valid=1, tx_data=in_data, word counter +1.
  - On the handshake of word PAYLOAD_WORDS (counter == PAYLOAD_WORDS-1):
    - tx_end_of_frame=1
    - seq+1
    - pkt_count+1
    - go to GAP, or to IDLE if GAP_CYCLES==0.
  - Cycles without a handshake drive tx_valid=0; gaps inside a frame are legal toward the core.
- **GAP**
  - in_ready=0.
  - Counts GAP_CYCLES cycles, then goes to IDLE.
- **enable** is only checked in IDLE. Deasserting it mid-frame lets the current frame complete.
- **Destination**: tx_dest_ip/tx_dest_port are constant from HDR through end-of-frame. Changes on dest_* mid-frame are ignored.
- **Counters**
  - seq is 48 bits and wraps from 2^48-1 to 0.
  - pkt_count wraps from 2^32-1 to 0.
  - overflow_count increments on every cycle tx_overflow==1 and saturates at 16'hFFFF. It is independent of FSM state.
- **Reset, asserted at any time**
  - FSM returns to IDLE and all counters clear.
  - A partial frame is abandoned with no end_of_frame issued; the core is reset alongside.

## Timing
- Reset values:
  - in_ready, tx_valid, tx_end_of_frame: 0
  - tx_data, tx_dest_ip, tx_dest_port: 0
  - pkt_count, overflow_count, seq: 0
  - state: IDLE
- tx_* outputs are registered. The cycle after a handshake carries that word on tx_data with tx_valid=1, so latency is 1 clk.
- tx_valid is a single-cycle strobe per word; there is no hold or retry. tx_end_of_frame is high only together with tx_valid.
- IDLE→HDR takes 1 cycle after the start condition. The header appears on tx_* in the cycle after entry to HDR.
- The first payload handshake can occur in the cycle after HDR.
- Minimum frame period = PAYLOAD_WORDS + 2 + GAP_CYCLES cycles (IDLE + HDR + payload + gap).
- tx_afull rising while in PAY drops in_ready in the same cycle. At most one further word (the registered one) reaches the core after afull is seen.
- Simultaneous last-word handshake and tx_overflow: both counters update in the same cycle.

## Test plan
- **Basic frame**: PAYLOAD_WORDS=4, GAP_CYCLES=2, enable=1, in_valid always high, in_data=1,2,3,4,… → tx_data sequence A55A_0000_0000_0000, 1, 2, 3, 4; end_of_frame on word 4 only; pkt_count=1. The next header is A55A_0000_0000_0001 and arrives exactly 8 cycles after the first.
- **Back-pressure**: tx_afull high for 10 cycles in mid-payload → in_ready low in the same cycles and no words lost or duplicated. After release the frame completes with 4 words in order.
- **Source starvation**: in_valid toggles every other cycle → tx_valid gaps match the input gaps; frame contents are unchanged.
- **Disable and destination change mid-frame**: enable dropped and dest_ip changed at word 2 → frame completes with the original tx_dest_ip, then the block stays in IDLE. Re-enabling with the new dest_ip → the next frame carries the new IP.
- **Overflow and wrap**: tx_overflow held high for 70000 cycles → overflow_count=16'hFFFF. Preloaded seq=2^48-1 → next header low bits read 0.
- **Async reset mid-frame**: rst_n low asynchronously while in PAY → all outputs 0 immediately. After release, the first header carries seq 0.
